aes_256_ctr_front: RTL and testbench

- CTR-mode control stage wrapped around the pipelined AES-256 core.
- Accepts key/IV configuration and sequences the core's key expansion handshake.
- Issues one counter block per cycle into the core's state input and XORs core output with the matching data block, delayed to align with it.
- Buffers results in an output FIFO with credit-based flow control, because the core pipeline has no stall.

---
 rtl/aes_256_ctr_front_pkg.sv | 16 +
 rtl/aes_ctr_out_fifo.sv | 47 ++++
 rtl/aes_256_ctr_front.sv | 124 ++++++++++++
 tb/tb_aes_256_ctr_front.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_256_ctr_front_pkg.sv
// rtl/aes_256_ctr_front_pkg.sv - shared widths and FSM encoding for the CTR front end
package aes_256_ctr_front_pkg;

  localparam int BLOCK_W = 128;
  localparam int KEY_W   = 256;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEY_START,
    ST_KEY_CLR,
    ST_KEY_WAIT,
    ST_RUN,
    ST_DRAIN
  } ctr_state_e;

endpackage

// File: rtl/aes_ctr_out_fifo.sv
// rtl/aes_ctr_out_fifo.sv - first-word-fall-through result FIFO with occupancy count
module aes_ctr_out_fifo #(
  parameter int WIDTH = 129,
  parameter int DEPTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             full;
  logic             do_rd;

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_rd   = rd_en && !empty;
  // Head is forced to zero while empty so the output bus is quiet between messages.
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  no_overflow: assert property (@(posedge clk) disable iff (reset) !(wr_en && full && !do_rd));

endmodule

// File: rtl/aes_256_ctr_front.sv
// rtl/aes_256_ctr_front.sv - CTR-mode sequencing, keystream alignment and output buffering
// around a fixed-latency, non-stalling AES-256 core.
module aes_256_ctr_front
  import aes_256_ctr_front_pkg::*;
#(
  parameter int PIPE_LAT   = 15,
  parameter int CTR_BITS   = 32,
  parameter int FIFO_DEPTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [KEY_W-1:0]   cfg_key,
  input  logic [BLOCK_W-1:0] cfg_iv,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [BLOCK_W-1:0] in_data,
  input  logic               in_last,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [BLOCK_W-1:0] out_data,
  output logic               out_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [KEY_W-1:0]   core_key,
  output logic               core_key_start,
  input  logic               core_key_valid,
  output logic [BLOCK_W-1:0] core_state,
  input  logic [BLOCK_W-1:0] core_out
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  ctr_state_e         state, state_nxt;
  logic [BLOCK_W-1:0] ctr, ctr_inc;
  logic               fire, credit_ok, tail_valid, fifo_empty;
  logic [CNT_W-1:0]   inflight, fifo_count;
  logic [PIPE_LAT-1:0] dl_valid, dl_last;
  logic [BLOCK_W-1:0] dl_data [PIPE_LAT];
  logic [BLOCK_W:0]   fifo_rd;

  // The core cannot stall, so a block is only issued when its result slot is already reserved.
  assign credit_ok  = ({1'b0, inflight} + {1'b0, fifo_count}) < (CNT_W+1)'(FIFO_DEPTH);
  assign fire       = in_valid && in_ready;
  assign core_state = ctr;
  assign tail_valid = dl_valid[PIPE_LAT-1];

  always_comb begin
    ctr_inc = ctr;
    ctr_inc[CTR_BITS-1:0] = ctr[CTR_BITS-1:0] + CTR_BITS'(1);
  end

  always_comb begin
    state_nxt      = state;
    cfg_ready      = 1'b0;
    in_ready       = 1'b0;
    core_key_start = 1'b0;
    case (state)
      ST_IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) state_nxt = ST_KEY_START;
      end
      ST_KEY_START: begin
        core_key_start = 1'b1;
        state_nxt      = ST_KEY_CLR;
      end
      // A valid still high here belongs to the previous key.
      ST_KEY_CLR:  if (!core_key_valid) state_nxt = ST_KEY_WAIT;
      ST_KEY_WAIT: if (core_key_valid)  state_nxt = ST_RUN;
      ST_RUN: begin
        in_ready = credit_ok;
        if (in_valid && credit_ok && in_last) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: if (inflight == '0 && fifo_empty) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      core_key <= '0;
      ctr      <= '0;
      dl_valid <= '0;
      inflight <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && cfg_valid) begin
        core_key <= cfg_key;
        ctr      <= cfg_iv;
      end else if (fire) begin
        ctr <= ctr_inc;
      end
      dl_valid <= {dl_valid[PIPE_LAT-2:0], fire};
      if (fire && !tail_valid)      inflight <= inflight + CNT_W'(1);
      else if (!fire && tail_valid) inflight <= inflight - CNT_W'(1);
    end
  end

  // Payload side of the delay line; only the valid bits need clearing.
  always_ff @(posedge clk) begin
    dl_data[0] <= in_data;
    for (int i = 1; i < PIPE_LAT; i++) dl_data[i] <= dl_data[i-1];
    dl_last <= {dl_last[PIPE_LAT-2:0], in_last};
  end

  aes_ctr_out_fifo #(
    .WIDTH (BLOCK_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (tail_valid),
    .wr_data ({dl_last[PIPE_LAT-1], core_out ^ dl_data[PIPE_LAT-1]}),
    .rd_en   (out_ready),
    .rd_data (fifo_rd),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_rd[BLOCK_W-1:0];
  assign out_last  = fifo_rd[BLOCK_W];

endmodule

// File: tb/tb_aes_256_ctr_front.sv
// tb/tb_aes_256_ctr_front.sv - bench for aes_256_ctr_front with a stand-in AES core
// and an in-order keystream scoreboard.
module tb_aes_256_ctr_front;

  localparam int PIPE_LAT   = 15;
  localparam int CTR_BITS   = 32;
  localparam int FIFO_DEPTH = 32;
  localparam int KEY_LAT    = 6;

  localparam logic [255:0] FIPS_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] cfg_key;
  logic [127:0] cfg_iv;
  logic         cfg_valid, cfg_ready;
  logic [127:0] in_data;
  logic         in_last, in_valid, in_ready;
  logic [127:0] out_data;
  logic         out_last, out_valid, out_ready;
  logic [255:0] core_key;
  logic         core_key_start;
  logic         core_key_valid = 1'b0;
  logic [127:0] core_state, core_out;

  always #5 clk = ~clk;

  aes_256_ctr_front #(
    .PIPE_LAT(PIPE_LAT), .CTR_BITS(CTR_BITS), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .cfg_key(cfg_key), .cfg_iv(cfg_iv), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .in_data(in_data), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .core_key(core_key), .core_key_start(core_key_start), .core_key_valid(core_key_valid),
    .core_state(core_state), .core_out(core_out)
  );

  // Stand-in cipher: exact for the FIPS-197 AES-256 vector, a keyed mix otherwise.
  function automatic logic [127:0] core_fn(input logic [255:0] k, input logic [127:0] s);
    if (k == FIPS_KEY && s == FIPS_PT) return FIPS_CT;
    return {s[63:0], s[127:64]} ^ k[255:128] ^ (s + k[127:0]) ^ {s[95:0], s[127:96]};
  endfunction

  logic [127:0] core_pipe [PIPE_LAT];
  int           key_busy = 0;

  always @(posedge clk) begin
    core_pipe[0] <= core_fn(core_key, core_state);
    for (int i = 1; i < PIPE_LAT; i++) core_pipe[i] <= core_pipe[i-1];
    if (core_key_start) begin
      core_key_valid <= 1'b0;
      key_busy       <= KEY_LAT;
    end else if (key_busy > 0) begin
      key_busy <= key_busy - 1;
      if (key_busy == 1) core_key_valid <= 1'b1;
    end
  end
  assign core_out = core_pipe[PIPE_LAT-1];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [128:0] exp_q [$];
  logic [127:0] st_log [$];
  logic [128:0] exp_head;
  logic [255:0] m_key;
  logic [127:0] m_ctr;
  logic [127:0] last_out_data;
  logic         last_out_last;
  int           outstanding = 0;
  logic         pending = 1'b0, saw_low = 1'b0, prev_start = 1'b0, kv_at_start = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      outstanding = 0;
      pending     = 1'b0;
      prev_start  = 1'b0;
    end else begin
      if (cfg_valid && cfg_ready) begin
        m_key = cfg_key;
        m_ctr = cfg_iv;
      end
      if (core_key_start) begin
        chk("start_pulse_width", 256'(prev_start), 256'(0));
        chk("core_key_hold", core_key, m_key);
        kv_at_start = core_key_valid;
        pending     = 1'b1;
        saw_low     = 1'b0;
      end else if (pending) begin
        if (!core_key_valid) saw_low = 1'b1;
        else if (saw_low)    pending = 1'b0;
      end
      prev_start = core_key_start;
      if (in_valid && in_ready) begin
        chk("fire_within_credit", 256'(outstanding < FIFO_DEPTH), 256'(1));
        chk("fire_after_key_ready", 256'(pending), 256'(0));
        chk("core_state", 256'(core_state), 256'(m_ctr));
        st_log.push_back(core_state);
        exp_q.push_back({in_last, in_data ^ core_fn(m_key, m_ctr)});
        m_ctr[CTR_BITS-1:0] = m_ctr[CTR_BITS-1:0] + 32'd1;
        outstanding++;
      end
      chk("inflight_bound", 256'(int'(dut.inflight) <= PIPE_LAT), 256'(1));
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected: got %0h with nothing outstanding", out_data);
        end else begin
          exp_head = exp_q.pop_front();
          chk("out_data", 256'(out_data), 256'(exp_head[127:0]));
          chk("out_last", 256'(out_last), 256'(exp_head[128]));
        end
        last_out_data = out_data;
        last_out_last = out_last;
        outstanding--;
      end
    end
  end

  logic rand_ready = 1'b0;
  initial forever begin
    @(posedge clk); #1;
    if (rand_ready) out_ready = 1'($urandom_range(1));
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic configure(input logic [255:0] k, input logic [127:0] iv);
    int n = 0;
    cfg_key = k; cfg_iv = iv; cfg_valid = 1'b1;
    while (!cfg_ready && n < 500) begin tick; n++; end
    chk("cfg_accept", 256'(cfg_ready), 256'(1));
    tick;
    cfg_valid = 1'b0;
  endtask

  task automatic send_msg(input int nblk, input int gap_pct, input bit zero, input bit with_last,
                          input int max_cycles, output int sent);
    int  guard = 0;
    bit  fired;
    sent = 0;
    while (sent < nblk && guard < max_cycles) begin
      if (!in_valid && int'($urandom_range(99)) >= gap_pct) begin
        in_valid = 1'b1;
        in_data  = zero ? '0 : {$urandom, $urandom, $urandom, $urandom};
        in_last  = with_last && (sent == nblk - 1);
      end
      @(negedge clk);
      fired = in_valid && in_ready;
      tick;
      if (fired) begin sent++; in_valid = 1'b0; in_last = 1'b0; end
      guard++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!(cfg_ready && !out_valid) && n < 3000) begin tick; n++; end
    chk(name, 256'(cfg_ready && !out_valid), 256'(1));
    chk({name, "_drained"}, 256'(exp_q.size()), 256'(0));
  endtask

  int sent;

  initial begin
    reset = 1'b1; cfg_key = '0; cfg_iv = '0; cfg_valid = 1'b0;
    in_data = '0; in_last = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) tick;
    reset = 1'b0;
    chk("rst_cfg_ready", 256'(cfg_ready), 256'(1));
    chk("rst_in_ready", 256'(in_ready), 256'(0));
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_out_last", 256'(out_last), 256'(0));
    chk("rst_out_data", 256'(out_data), 256'(0));
    chk("rst_key_start", 256'(core_key_start), 256'(0));
    chk("rst_core_key", core_key, 256'(0));
    chk("rst_core_state", 256'(core_state), 256'(0));
    out_ready = 1'b1;

    configure(FIPS_KEY, FIPS_PT);
    send_msg(1, 0, 1'b1, 1'b1, 500, sent);
    wait_idle("fips_idle");
    chk("fips_ct", 256'(last_out_data), 256'(FIPS_CT));
    chk("fips_last", 256'(last_out_last), 256'(1));

    st_log.delete();
    configure({128'h0, 128'h1234}, 128'hcafebabe_01234567_89abcdef_ffffffff);
    send_msg(2, 0, 1'b0, 1'b1, 500, sent);
    wait_idle("wrap_idle");
    chk("wrap_blocks", 256'(st_log.size()), 256'(2));
    if (st_log.size() == 2) begin
      chk("wrap_state0", 256'(st_log[0]), 256'(128'hcafebabe_01234567_89abcdef_ffffffff));
      chk("wrap_state1", 256'(st_log[1]), 256'(128'hcafebabe_01234567_89abcdef_00000000));
    end

    out_ready = 1'b0;
    configure({$urandom, $urandom, 192'h5a5a}, 128'h1);
    send_msg(40, 0, 1'b0, 1'b1, 80, sent);
    chk("bp_accepted", 256'(sent), 256'(FIFO_DEPTH));
    chk("bp_in_ready_low", 256'(in_ready), 256'(0));
    chk("bp_out_valid", 256'(out_valid), 256'(1));
    out_ready = 1'b1;
    send_msg(8, 0, 1'b0, 1'b1, 3000, sent);
    wait_idle("bp_idle");

    rand_ready = 1'b1;
    configure({$urandom, $urandom, $urandom, $urandom, 128'h77}, {$urandom, $urandom, $urandom, $urandom});
    send_msg(64, 50, 1'b0, 1'b1, 5000, sent);
    chk("sparse_sent", 256'(sent), 256'(64));
    rand_ready = 1'b0;
    tick;
    out_ready = 1'b1;
    wait_idle("sparse_idle");

    configure({128'hfeed, 128'hbeef}, 128'h42);
    send_msg(5, 0, 1'b0, 1'b1, 3000, sent);
    chk("rekey_stale_valid", 256'(kv_at_start), 256'(1));
    wait_idle("rekey_idle");

    configure({128'h9, 128'h3}, 128'h100);
    send_msg(10, 0, 1'b0, 1'b0, 3000, sent);
    chk("rst_run_sent", 256'(sent), 256'(10));
    reset = 1'b1;
    tick;
    chk("rst_run_out_valid", 256'(out_valid), 256'(0));
    chk("rst_run_cfg_ready", 256'(cfg_ready), 256'(1));
    reset = 1'b0;
    configure({128'h31, 128'h41}, 128'h59);
    send_msg(6, 0, 1'b0, 1'b1, 3000, sent);
    wait_idle("post_reset_idle");
    repeat (PIPE_LAT + 4) tick;
    chk("post_reset_quiet", 256'(out_valid), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
